// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory; one access per three cycles.
// Optional address bounds checking is enabled by defining MEM_ARB_BOUNDS_CHECK_EN.
module memory_arbiter #(
   parameter int unsigned MEM_SIZE = 4016
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        p0_req,
   input  logic        p0_write,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p1_req,
   input  logic        p1_write,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic        err,
   output logic [31:0] mem_address,
   output logic        mem_mode,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif
   localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_SIZE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          state, state_n;
   logic            grant, grant_n;
   logic            last_grant, last_grant_n;
   logic            is_write, is_write_n;
   logic            oob, oob_n;
   logic            p0_ack_n, p1_ack_n, err_n, mem_mode_n;
   logic [DW-1:0]   p0_rdata_n, p1_rdata_n, mem_data_in_n;
   logic [AW-1:0]   mem_address_n;

   logic            sel_c, sel_write_c, sel_oob_c;
   logic [AW-1:0]   sel_addr_c;
   logic [DW-1:0]   sel_wdata_c, rdata_c;

   // Arbitration: a lone requester wins, otherwise the port not served last.
   always_comb begin
      sel_c       = (p0_req && p1_req) ? ~last_grant : p1_req;
      sel_write_c = sel_c ? p1_write : p0_write;
      sel_addr_c  = sel_c ? p1_addr  : p0_addr;
      sel_wdata_c = sel_c ? p1_wdata : p0_wdata;
      sel_oob_c   = BOUNDS_EN && (sel_addr_c >= MEM_LIMIT);
      rdata_c     = (is_write || oob) ? '0 : mem_data_out;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_n       = state;
      grant_n       = grant;
      last_grant_n  = last_grant;
      is_write_n    = is_write;
      oob_n         = oob;
      p0_rdata_n    = p0_rdata;
      p1_rdata_n    = p1_rdata;
      p0_ack_n      = 1'b0;
      p1_ack_n      = 1'b0;
      err_n         = 1'b0;
      mem_mode_n    = 1'b0;
      mem_address_n = '0;
      mem_data_in_n = '0;

      case (state)
         IDLE: begin
            if (p0_req || p1_req) begin
               state_n       = ACCESS;
               grant_n       = sel_c;
               last_grant_n  = sel_c;
               is_write_n    = sel_write_c;
               oob_n         = sel_oob_c;
               mem_mode_n    = sel_write_c && !sel_oob_c;
               mem_address_n = sel_oob_c ? '0 : sel_addr_c;
               mem_data_in_n = sel_oob_c ? '0 : sel_wdata_c;
            end
         end
         ACCESS: begin
            state_n = RESP;
            err_n   = oob;
            if (grant) begin
               p1_rdata_n = rdata_c;
               p1_ack_n   = 1'b1;
            end else begin
               p0_rdata_n = rdata_c;
               p0_ack_n   = 1'b1;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         is_write    <= 1'b0;
         oob         <= 1'b0;
         p0_ack      <= 1'b0;
         p1_ack      <= 1'b0;
         p0_rdata    <= '0;
         p1_rdata    <= '0;
         err         <= 1'b0;
         mem_mode    <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
      end else begin
         state       <= state_n;
         grant       <= grant_n;
         last_grant  <= last_grant_n;
         is_write    <= is_write_n;
         oob         <= oob_n;
         p0_ack      <= p0_ack_n;
         p1_ack      <= p1_ack_n;
         p0_rdata    <= p0_rdata_n;
         p1_rdata    <= p1_rdata_n;
         err         <= err_n;
         mem_mode    <= mem_mode_n;
         mem_address <= mem_address_n;
         mem_data_in <= mem_data_in_n;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: behavioural memory, ack scoreboard, per-scenario timing checks.
module tb_memory_arbiter;

   localparam int unsigned MEM_WORDS = 4016;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
   localparam bit EXP_BOUNDS = 1'b1;
`else
   localparam bit EXP_BOUNDS = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        p0_req = 1'b0, p0_write = 1'b0, p1_req = 1'b0, p1_write = 1'b0;
   logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
   logic        p0_ack, p1_ack, err, mem_mode;
   logic [31:0] p0_rdata, p1_rdata, mem_address, mem_data_in, mem_data_out;

   logic [31:0] tb_mem [0:MEM_WORDS-1];

   typedef struct packed {
      logic        port;
      logic [31:0] rdata;
      logic        err;
   } sb_t;
   sb_t sb[$];
   sb_t exp_e;

   int tests_run = 0;
   int tests_failed = 0;

   memory_arbiter #(.MEM_SIZE(MEM_WORDS)) dut (
      .clock(clock), .reset_n(reset_n),
      .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .err(err), .mem_address(mem_address), .mem_mode(mem_mode),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clock = ~clock;

   // Behavioural memory: pattern-initialised, combinational read, write on rising edge.
   initial begin
      for (int i = 0; i < int'(MEM_WORDS); i++) tb_mem[i] = 32'hA500_0000 | 32'(i);
      forever begin
         @(posedge clock);
         if (mem_mode && mem_address < 32'(MEM_WORDS)) tb_mem[mem_address[11:0]] <= mem_data_in;
      end
   end

   always_comb begin
      mem_data_out = 32'h0;
      if (mem_address < 32'(MEM_WORDS)) mem_data_out = tb_mem[mem_address[11:0]];
   end

   // Scoreboard: every ack must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset_n && (p0_ack || p1_ack)) begin
         tests_run++;
         if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_ack: p0_ack=%0b p1_ack=%0b, none expected", p0_ack, p1_ack);
         end else begin
            exp_e = sb.pop_front();
            if ((p0_ack && p1_ack) || (p1_ack !== exp_e.port) ||
                ((p1_ack ? p1_rdata : p0_rdata) !== exp_e.rdata) || (err !== exp_e.err)) begin
               tests_failed++;
               $display("FAIL sb_ack: got p0_ack=%0b p1_ack=%0b rdata=%h err=%0b, want port=%0d rdata=%h err=%0b",
                        p0_ack, p1_ack, p1_ack ? p1_rdata : p0_rdata, err, exp_e.port, exp_e.rdata, exp_e.err);
            end
         end
      end
   end

   task automatic issue_req(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      if (port) begin
         p1_req = 1'b1; p1_write = wr; p1_addr = addr; p1_wdata = data;
      end else begin
         p0_req = 1'b1; p0_write = wr; p0_addr = addr; p0_wdata = data;
      end
   endtask

   task automatic drop_req(input bit port);
      if (port) p1_req = 1'b0;
      else      p0_req = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      tests_run++;
      if ({p0_ack, p1_ack, err, mem_mode, p0_rdata, p1_rdata, mem_address, mem_data_in} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ack=%b%b err=%b mode=%b rd0=%h rd1=%h addr=%h din=%h, want all 0",
                  p0_ack, p1_ack, err, mem_mode, p0_rdata, p1_rdata, mem_address, mem_data_in);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      @(posedge clock); #1;
      sb.push_back('{port: 1'b0, rdata: 32'h0, err: 1'b0});
      issue_req(1'b0, 1'b1, 32'h22, 32'hFFFF_FFFF);
      @(negedge clock);
      tests_run++;
      if (mem_mode !== 1'b0) begin tests_failed++; $display("FAIL wr_idle_mode: got %b want 0", mem_mode); end
      @(negedge clock);
      tests_run++;
      if (mem_mode !== 1'b1 || mem_address !== 32'h22 || mem_data_in !== 32'hFFFF_FFFF || p0_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL wr_access: mode=%b addr=%h din=%h ack=%b, want 1 00000022 ffffffff 0", mem_mode, mem_address, mem_data_in, p0_ack);
      end
      @(negedge clock);
      tests_run++;
      if (p0_ack !== 1'b1 || mem_mode !== 1'b0) begin
         tests_failed++; $display("FAIL wr_resp: ack=%b mode=%b, want 1 0", p0_ack, mem_mode);
      end
      drop_req(1'b0);
      @(negedge clock);
      tests_run++;
      if (p0_ack !== 1'b0 || tb_mem[32'h22] !== 32'hFFFF_FFFF) begin
         tests_failed++; $display("FAIL wr_done: ack=%b mem=%h, want 0 ffffffff", p0_ack, tb_mem[32'h22]);
      end
      @(posedge clock); #1;
      sb.push_back('{port: 1'b0, rdata: 32'hFFFF_FFFF, err: 1'b0});
      issue_req(1'b0, 1'b0, 32'h22, 32'h0);
      repeat (3) @(negedge clock);
      tests_run++;
      if (p0_ack !== 1'b1 || p0_rdata !== 32'hFFFF_FFFF) begin
         tests_failed++; $display("FAIL rd_resp: ack=%b rdata=%h, want 1 ffffffff", p0_ack, p0_rdata);
      end
      drop_req(1'b0);
   endtask

   task automatic test_contention();
      @(posedge clock); #1;
      reset_n = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{port: 1'b0, rdata: 32'hA500_0001, err: 1'b0});
         sb.push_back('{port: 1'b1, rdata: 32'hA500_0000, err: 1'b0});
      end
      issue_req(1'b0, 1'b0, 32'h1, 32'h0);
      issue_req(1'b1, 1'b0, 32'h0, 32'h0);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clock);
         tests_run++;
         if (p0_ack !== (k == 3 || k == 9) || p1_ack !== (k == 6 || k == 12)) begin
            tests_failed++;
            $display("FAIL alt_ack_c%0d: p0_ack=%b p1_ack=%b, want %b %b", k, p0_ack, p1_ack, (k == 3 || k == 9), (k == 6 || k == 12));
         end
         if (k == 2 || k == 5) begin
            tests_run++;
            if (mem_address !== ((k == 2) ? 32'h1 : 32'h0)) begin
               tests_failed++; $display("FAIL alt_addr_c%0d: got %h want %h", k, mem_address, (k == 2) ? 32'h1 : 32'h0);
            end
         end
         if (k == 12) begin drop_req(1'b0); drop_req(1'b1); end
      end
   endtask

   task automatic test_cross_port();
      @(posedge clock); #1;
      sb.push_back('{port: 1'b1, rdata: 32'h0, err: 1'b0});
      issue_req(1'b1, 1'b1, 32'h23, 32'h0000_5555);
      repeat (2) @(negedge clock);
      tests_run++;
      if (mem_mode !== 1'b1 || mem_address !== 32'h23 || mem_data_in !== 32'h5555) begin
         tests_failed++; $display("FAIL p1_wr_access: mode=%b addr=%h din=%h, want 1 00000023 00005555", mem_mode, mem_address, mem_data_in);
      end
      @(negedge clock);
      drop_req(1'b1);
      @(posedge clock); #1;
      sb.push_back('{port: 1'b0, rdata: 32'h0000_5555, err: 1'b0});
      issue_req(1'b0, 1'b0, 32'h23, 32'h0);
      repeat (3) @(negedge clock);
      tests_run++;
      if (p0_ack !== 1'b1 || p0_rdata !== 32'h5555 || p1_rdata !== 32'h0 || p1_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL cross_read: p0_ack=%b p0_rdata=%h p1_rdata=%h p1_ack=%b, want 1 00005555 00000000 0", p0_ack, p0_rdata, p1_rdata, p1_ack);
      end
      drop_req(1'b0);
   endtask

   task automatic test_back_to_back();
      @(posedge clock); #1;
      sb.push_back('{port: 1'b0, rdata: 32'hFFFF_FFFF, err: 1'b0});
      sb.push_back('{port: 1'b0, rdata: 32'hFFFF_FFFF, err: 1'b0});
      issue_req(1'b0, 1'b0, 32'h22, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         tests_run++;
         if (p0_ack !== (k == 3 || k == 6) ||
             mem_address !== ((k == 2 || k == 5) ? 32'h22 : 32'h0)) begin
            tests_failed++;
            $display("FAIL b2b_c%0d: ack=%b addr=%h, want %b %h", k, p0_ack, mem_address,
                     (k == 3 || k == 6), (k == 2 || k == 5) ? 32'h22 : 32'h0);
         end
         if (k == 6) drop_req(1'b0);
      end
   endtask

   task automatic test_bounds();
      @(posedge clock); #1;
      sb.push_back('{port: 1'b0, rdata: 32'h0, err: EXP_BOUNDS});
      issue_req(1'b0, 1'b1, 32'd4016, 32'hDEAD_BEEF);
      repeat (2) @(negedge clock);
      tests_run++;
      if (mem_mode !== !EXP_BOUNDS || mem_address !== (EXP_BOUNDS ? 32'h0 : 32'd4016)) begin
         tests_failed++;
         $display("FAIL oob_access: mode=%b addr=%h, want %b %h", mem_mode, mem_address, !EXP_BOUNDS, EXP_BOUNDS ? 32'h0 : 32'd4016);
      end
      @(negedge clock);
      tests_run++;
      if (p0_ack !== 1'b1 || err !== EXP_BOUNDS || p0_rdata !== 32'h0) begin
         tests_failed++; $display("FAIL oob_resp: ack=%b err=%b rdata=%h, want 1 %b 0", p0_ack, err, p0_rdata, EXP_BOUNDS);
      end
      drop_req(1'b0);
      @(negedge clock);
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("FAIL oob_err_clear: got %b want 0", err); end
   endtask

   task automatic test_reset_mid_access();
      @(posedge clock); #1;
      issue_req(1'b0, 1'b1, 32'h24, 32'h1234);
      repeat (2) @(negedge clock);
      tests_run++;
      if (mem_mode !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_access: mode=%b want 1", mem_mode); end
      reset_n = 1'b0;
      drop_req(1'b0);
      #1;
      tests_run++;
      if ({p0_ack, p1_ack, err, mem_mode, p0_rdata, p1_rdata, mem_address, mem_data_in} !== '0) begin
         tests_failed++;
         $display("FAIL rst_mid_outputs: ack=%b%b err=%b mode=%b rd0=%h rd1=%h addr=%h din=%h, want all 0",
                  p0_ack, p1_ack, err, mem_mode, p0_rdata, p1_rdata, mem_address, mem_data_in);
      end
      repeat (2) @(negedge clock);
      tests_run++;
      if (tb_mem[32'h24] !== 32'hA500_0024 || p0_ack !== 1'b0) begin
         tests_failed++; $display("FAIL rst_mid_mem: mem=%h ack=%b, want a5000024 0", tb_mem[32'h24], p0_ack);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_contention();
      test_cross_port();
      test_back_to_back();
      test_bounds();
      test_reset_mid_access();
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++; $display("FAIL sb_leftover: %0d acks never arrived, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 4016, number of 32-bit words in the attached memory.
REQ-002 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports p0_req/p1_req  input  1 each  requester N wants one access.
REQ-005 SHALL have ports p0_write/p1_write  input  1 each  1=write, 0=read.
REQ-006 SHALL have ports p0_addr/p1_addr  input  32 each  word address.
REQ-007 SHALL have ports p0_wdata/p1_wdata  input  32 each  write data.
REQ-008 SHALL have ports p0_ack/p1_ack  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports p0_rdata/p1_rdata  output  32 each  read data, valid while ackN=1.
REQ-010 SHALL have port err  output  1  bounds error flag, valid with any ack.
REQ-011 SHALL have ports mem_address  output  32, mem_mode  output  1 (1=write), mem_data_in  output  32, mem_data_out  input  32 (combinational read, write on rising edge when mem_mode=1).

Function
REQ-012 SHALL implement states IDLE, ACCESS, RESP; IDLE->ACCESS when any req=1 at the edge; ACCESS->RESP always; RESP->IDLE always.
REQ-013 SHALL, in IDLE, select the granted port: only one req -> that port; both -> port not equal to last_grant; record it in grant and last_grant at the IDLE->ACCESS edge.
REQ-014 SHALL, in ACCESS, drive mem_address=addr, mem_data_in=wdata, mem_mode=write of the granted port for exactly one cycle.
REQ-015 SHALL, at the ACCESS->RESP edge, capture mem_data_out into the granted port's rdata register (reads); for writes, rdata register SHALL be loaded with 0.
REQ-016 SHALL assert ack of the granted port only during RESP; the other ack remains 0.
REQ-017 SHALL drive mem_mode=0, mem_address=0, mem_data_in=0 in IDLE and RESP.
REQ-018 SHALL hold each rdata output unchanged outside its own RESP cycle.
REQ-019 Requesters SHALL hold req, write, addr, wdata stable from assertion until ack seen; a requester dropping req before ack is a protocol violation, and the arbiter SHALL still complete the latched access.
REQ-020 SHALL give latency: req sampled at edge E -> ACCESS in cycle E+1 -> ack in cycle E+2; one access per 3 cycles maximum.
REQ-021 SHALL, with both reqs held continuously, alternate grants 0,1,0,1,...
REQ-022 SHALL ignore a req still high during RESP; it is re-arbitrated in the following IDLE cycle (requester must deassert within RESP to avoid a repeat access).

Reset
REQ-023 SHALL, on reset_n=0, immediately force state=IDLE, grant=0, last_grant=1, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, err=0, mem_mode=0, mem_address=0, mem_data_in=0.
REQ-024 SHALL, on reset during ACCESS, suppress the pending write (mem_mode falls to 0 combinationally with reset) and emit no ack.
REQ-025 SHALL grant port 0 first when both request in the first cycle after reset release.

Configuration
REQ-026 SHALL honour macro MEM_ARB_BOUNDS_CHECK_EN.
REQ-027 With MEM_ARB_BOUNDS_CHECK_EN defined: an access with addr >= MEM_SIZE SHALL keep mem_mode=0, mem_address=0 during ACCESS, return rdata=0, and assert err=1 in its RESP cycle; err=0 otherwise.
REQ-028 Without MEM_ARB_BOUNDS_CHECK_EN: all addresses SHALL be forwarded unchanged and err SHALL be tied to 0.

Verification
REQ-029 Reset, then p0 write addr=0x22 data=0xFFFFFFFF -> mem_mode=1 exactly one cycle at ACCESS, p0_ack pulse 2 cycles after req; p0 read 0x22 -> p0_rdata=0xFFFFFFFF with ack.
REQ-030 p0 and p1 raise req same cycle after reset (p0 read 0x1, p1 read 0x0) -> p0 acked first, p1 acked 3 cycles later; both held 12 cycles -> grants strictly alternate.
REQ-031 p1 writes 0x5555 to 0x23, then p0 reads 0x23 -> p0_rdata=0x00005555, p1_rdata unchanged during p0 ack.
REQ-032 Assert reset_n=0 mid-ACCESS of a p0 write to 0x24 data=0x1234 -> no ack, memory word 0x24 unchanged, all outputs at reset values.
REQ-033 With MEM_ARB_BOUNDS_CHECK_EN: p0 write addr=4016 -> mem_mode stays 0, err=1 and p0_ack=1 same cycle, rdata=0; without macro: mem_address=4016 driven, err=0.
REQ-034 p0 holds req through RESP -> second access starts one IDLE cycle later, ack again after 3 cycles.
